// File: rtl/operation_encoder.sv
// PS/2 scancode stream to per-player movement codes and a budgeted boost request.
// One instance per player; PLAYER selects WASD+LShift (0) or arrows+RShift (1).
module operation_encoder #(
    parameter int unsigned PLAYER          = 0,
    parameter logic [26:0] BOOST_CYCLES    = 27'd50_000_000,
    parameter logic [26:0] COOLDOWN_CYCLES = 27'd100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_byte,
    input  logic [2:0] state,
    output logic [1:0] h_code,
    output logic [1:0] v_code,
    output logic       boost
);
    localparam logic [2:0] ST_RACING = 3'd4;
    localparam logic [2:0] ST_PAUSE  = 3'd5;

    localparam logic [1:0] NIL   = 2'd0;
    localparam logic [1:0] LEFT  = 2'd1;
    localparam logic [1:0] RIGHT = 2'd2;
    localparam logic [1:0] UP    = 2'd1;
    localparam logic [1:0] DOWN  = 2'd2;

    localparam logic       DIR_EXT = (PLAYER != 0);
    localparam logic [7:0] K_UP    = (PLAYER == 0) ? 8'h1D : 8'h75;
    localparam logic [7:0] K_LEFT  = (PLAYER == 0) ? 8'h1C : 8'h6B;
    localparam logic [7:0] K_DOWN  = (PLAYER == 0) ? 8'h1B : 8'h72;
    localparam logic [7:0] K_RIGHT = (PLAYER == 0) ? 8'h23 : 8'h74;
    localparam logic [7:0] K_BOOST = (PLAYER == 0) ? 8'h12 : 8'h59;

    typedef enum logic [1:0] {P_IDLE, P_EXT, P_BRK, P_EXTBRK} prefix_t;
    typedef enum logic [1:0] {B_READY, B_ACTIVE, B_COOL, B_WAIT_REL} boost_t;

    prefix_t     p_state;
    boost_t      b_state;
    logic [26:0] cnt;
    logic        held_up, held_down, held_left, held_right, held_boost;
    logic        last_h;   // 1 = right pressed most recently
    logic        last_v;   // 1 = down pressed most recently

    logic ext, brk, is_code, dir_ok, boost_ok;
    logic hit_up, hit_down, hit_left, hit_right, hit_boost;

    always_comb begin
        ext       = (p_state == P_EXT) || (p_state == P_EXTBRK);
        brk       = (p_state == P_BRK) || (p_state == P_EXTBRK);
        is_code   = key_valid && (key_byte != 8'hE0) && (key_byte != 8'hF0);
        dir_ok    = is_code && (ext == DIR_EXT);
        boost_ok  = is_code && !ext;
        hit_up    = dir_ok && (key_byte == K_UP);
        hit_down  = dir_ok && (key_byte == K_DOWN);
        hit_left  = dir_ok && (key_byte == K_LEFT);
        hit_right = dir_ok && (key_byte == K_RIGHT);
        hit_boost = boost_ok && (key_byte == K_BOOST);
    end

    // Prefix tracking and held-key flags; a strobe coincident with rst is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_state    <= P_IDLE;
            held_up    <= 1'b0;
            held_down  <= 1'b0;
            held_left  <= 1'b0;
            held_right <= 1'b0;
            held_boost <= 1'b0;
            last_h     <= 1'b0;
            last_v     <= 1'b0;
        end else if (key_valid) begin
            case (key_byte)
                8'hE0:   p_state <= brk ? P_EXTBRK : P_EXT;
                8'hF0:   p_state <= ext ? P_EXTBRK : P_BRK;
                default: p_state <= P_IDLE;
            endcase
            if (hit_up)    held_up    <= !brk;
            if (hit_down)  held_down  <= !brk;
            if (hit_left)  held_left  <= !brk;
            if (hit_right) held_right <= !brk;
            if (hit_boost) held_boost <= !brk;
            if (hit_up    && !brk) last_v <= 1'b0;
            if (hit_down  && !brk) last_v <= 1'b1;
            if (hit_left  && !brk) last_h <= 1'b0;
            if (hit_right && !brk) last_h <= 1'b1;
        end
    end

    logic [1:0] h_res, v_res;

    always_comb begin
        h_res = NIL;
        if (held_left && held_right) h_res = last_h ? RIGHT : LEFT;
        else if (held_left)          h_res = LEFT;
        else if (held_right)         h_res = RIGHT;
        v_res = NIL;
        if (held_up && held_down)    v_res = last_v ? DOWN : UP;
        else if (held_up)            v_res = UP;
        else if (held_down)          v_res = DOWN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_code <= NIL;
            v_code <= NIL;
        end else begin
            h_code <= (state == ST_RACING) ? h_res : NIL;
            v_code <= (state == ST_RACING) ? v_res : NIL;
        end
    end

    // Boost budget: >= compares make the counter stop at the terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_state <= B_READY;
            cnt     <= '0;
            boost   <= 1'b0;
        end else if (state == ST_RACING) begin
            case (b_state)
                B_READY: begin
                    cnt <= '0;
                    if (held_boost) begin
                        b_state <= B_ACTIVE;
                        boost   <= 1'b1;
                    end else begin
                        boost   <= 1'b0;
                    end
                end
                B_ACTIVE: begin
                    if (!held_boost) begin
                        b_state <= B_READY;
                        cnt     <= '0;
                        boost   <= 1'b0;
                    end else if (cnt >= BOOST_CYCLES - 27'd1) begin
                        b_state <= B_COOL;
                        cnt     <= '0;
                        boost   <= 1'b0;
                    end else begin
                        cnt     <= cnt + 27'd1;
                        boost   <= 1'b1;
                    end
                end
                B_COOL: begin
                    boost <= 1'b0;
                    if (cnt >= COOLDOWN_CYCLES - 27'd1) begin
                        b_state <= B_WAIT_REL;
                        cnt     <= '0;
                    end else begin
                        cnt     <= cnt + 27'd1;
                    end
                end
                default: begin
                    boost <= 1'b0;
                    if (!held_boost) b_state <= B_READY;
                end
            endcase
        end else if (state == ST_PAUSE) begin
            boost <= 1'b0;
        end else begin
            b_state <= B_READY;
            cnt     <= '0;
            boost   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operation_encoder.sv
// Directed bench: u0 = WASD player with a short boost budget, u1 = arrow-key player.
module tb_operation_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_byte = 8'h00;
    logic [2:0] state = 3'd4;
    logic [1:0] h0, v0, h1, v1;
    logic       b0, b1;
    int         n_chk = 0;
    int         n_pass = 0;
    int         cnt;

    always #5 clk = ~clk;

    operation_encoder #(.PLAYER(0), .BOOST_CYCLES(27'd8), .COOLDOWN_CYCLES(27'd4)) u0 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_byte(key_byte),
        .state(state), .h_code(h0), .v_code(v0), .boost(b0));

    operation_encoder #(.PLAYER(1)) u1 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_byte(key_byte),
        .state(state), .h_code(h1), .v_code(v1), .boost(b1));

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Byte is sampled on the posedge inside; returns just after that edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        key_valid = 1'b1;
        key_byte  = b;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        key_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_h0", h0, 0); check("rst_v0", v0, 0); check("rst_b0", b0, 0);
        check("rst_h1", h1, 0); check("rst_v1", v1, 0); check("rst_b1", b1, 0);

        // basic make/break, two-cycle latency
        state = 3'd4;
        send(8'h1D);
        check("lat_v0_early", v0, 0);
        step();
        check("lat_v0_up", v0, 1);
        send(8'h23); step();
        check("wd_v0", v0, 1); check("wd_h0", h0, 2);
        check("p1_ignores_h", h1, 0); check("p1_ignores_v", v1, 0);
        send(8'hF0); send(8'h1D); step();
        check("brk_w_v0", v0, 0); check("brk_w_h0", h0, 2);

        // left/right conflict follows most recent make
        do_reset();
        send(8'h1C); send(8'h23); step();
        check("conf_right", h0, 2);
        send(8'hF0); send(8'h23); step();
        check("conf_left_left", h0, 1);
        send(8'hF0); send(8'h1C); step();
        check("conf_none", h0, 0);

        // extended arrows for player 1
        do_reset();
        send(8'hE0); send(8'h75); step();
        check("arr_up", v1, 1);
        check("arr_p0_ignores", v0, 0);
        send(8'hF0); send(8'h75); step();
        check("arr_nonext_brk_ignored", v1, 1);
        send(8'hE0); send(8'hF0); send(8'h75); step();
        check("arr_brk", v1, 0);
        send(8'hE0); send(8'h75);
        send(8'hF0); send(8'hE0); send(8'h75); step();
        check("arr_brk_swapped_prefix", v1, 0);
        send(8'h1D); step();
        check("arr_w_ignored", v1, 0);
        check("w_for_p0", v0, 1);

        // player 1 boost is non-extended RShift
        do_reset();
        send(8'hE0); send(8'h59); step();
        check("rshift_ext_ignored", b1, 0);
        send(8'h59); step();
        check("rshift_boost", b1, 1);

        // boost budget of 8, cooldown, no retrigger while held
        do_reset();
        send(8'h12);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin cnt += b0; step(); end
        check("boost_budget", cnt, 8);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin cnt += b0; step(); end
        check("boost_held_locked", cnt, 0);
        send(8'hF0); send(8'h12);
        send(8'h12);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin cnt += b0; step(); end
        check("boost_retrigger", cnt, 8);

        // held through countdown, then pause freezes the boost count
        do_reset();
        state = 3'd3;
        send(8'h1D); step();
        check("cd_gated", v0, 0);
        state = 3'd4;
        step();
        check("race_entry", v0, 1);
        send(8'h12); step();
        check("bst_on", b0, 1);
        step(); step();
        state = 3'd5;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin step(); cnt += b0; end
        check("pause_boost_off", cnt, 0);
        check("pause_v_gated", v0, 0);
        state = 3'd4;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin step(); cnt += b0; end
        check("boost_remaining", cnt, 5);

        // reset mid-sequence clears the prefix; strobe during rst dropped
        do_reset();
        send(8'hE0);
        @(negedge clk);
        rst = 1'b1; key_valid = 1'b1; key_byte = 8'hE0;
        @(negedge clk);
        rst = 1'b0; key_valid = 1'b0;
        check("mid_rst_h0", h0, 0); check("mid_rst_v0", v0, 0); check("mid_rst_b0", b0, 0);
        check("mid_rst_v1", v1, 0);
        send(8'h75); step(); step();
        check("mid_rst_75_ignored", v1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/operation_encoder.md
Name: operation_encoder

Overview:
- Converts the PS/2 scancode byte stream into per-player movement codes (h_code, v_code) and a boost flag for the physics engine.
- Tracks make/break events (including E0/F0 prefixes) for each player's four direction keys and boost key.
- Resolves opposing-key conflicts and enforces a timed boost budget with cooldown.
- Sits between the PS/2 byte receiver and one physics engine instance; one instance per player.

Parameters:
- PLAYER, 0, key map select. 0 = W/A/S/D plus LShift (all non-extended). 1 = arrow keys (E0-prefixed) plus RShift (non-extended).
- BOOST_CYCLES, 27'd50_000_000, maximum consecutive cycles boost stays asserted.
- COOLDOWN_CYCLES, 27'd100_000_000, cycles boost is locked out after a budget expiry.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe; key_byte is valid this cycle
- key_byte  in  8  received PS/2 byte
- state  in  3  game state: IDLE=0, SETTING=1, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6
- h_code  out  2  0=NIL, 1=LEFT, 2=RIGHT (registered)
- v_code  out  2  0=NIL, 1=UP, 2=DOWN (registered)
- boost  out  1  boost request (registered)

Behaviour:
- Reset: h_code=0, v_code=0, boost=0. All held flags, last-pressed registers, prefix FSM and boost FSM cleared; boost counter = 0.
- Prefix FSM: states P_IDLE, P_EXT, P_BRK, P_EXTBRK.
  - 8'hE0 sets the ext flag; 8'hF0 sets the brk flag. Flags accumulate in either order.
  - Any other byte is a key code. It completes the sequence and the FSM returns to P_IDLE.
  - Bytes are consumed only when key_valid=1.
- Key match table:
  - PLAYER 0, ext must be 0: W=1D up, A=1C left, S=1B down, D=23 right, LShift=12 boost.
  - PLAYER 1, ext must be 1: 75 up, 6B left, 72 down, 74 right.
  - PLAYER 1 boost: RShift=59 with ext=0.
  - Any code or ext mismatch is ignored; only the prefix FSM resets.
  - Make (brk=0) sets the held flag; break (brk=1) clears it. A repeated make (typematic) is harmless.
- Conflict resolution:
  - last_h records the most recent make of left or right; last_v records the most recent make of up or down.
  - Both keys of a pair held: the output follows last_h / last_v.
  - Exactly one held: that direction. None held: NIL.
- Latency: the key-code byte sampled at edge k updates the held flags at edge k. h_code/v_code/boost reflect it after edge k+1, i.e. two cycles from the key-code strobe.
- State gating:
  - h_code/v_code are driven only when state==RACING; otherwise 0.
  - Held flags keep tracking in all states, so a key held through COUNTDOWN is active on entry to RACING.
- Boost FSM: states B_READY, B_ACTIVE, B_COOL, B_WAIT_REL.
  - B_READY -> B_ACTIVE when the boost key is held and state==RACING. The counter is cleared.
  - B_ACTIVE: boost=1 and the counter increments each cycle.
    - Key released -> B_READY, counter cleared.
    - Counter reaches BOOST_CYCLES-1 -> B_COOL, counter cleared. Boost is therefore high for exactly BOOST_CYCLES cycles.
  - B_COOL: boost=0; the counter increments. At COOLDOWN_CYCLES-1 -> B_WAIT_REL.
  - B_WAIT_REL: -> B_READY once the boost key is not held. Holding the key never retriggers boost.
  - State PAUSE freezes the boost FSM and counter; boost output is forced to 0.
  - Any state other than RACING or PAUSE forces B_READY, counter 0, boost 0.
- Simultaneous events: one byte per strobe only. A key_valid pulse on the same edge as rst is discarded.
- The counter is 27 bits and saturates at the terminal compare; it never wraps.

Test Plan:
- PLAYER=0, state=4. Send 1D, then 23 -> after +2 cycles v_code=1, h_code=2. Send F0,1D -> v_code=0, h_code stays 2.
- PLAYER=0, state=4. Make 1C, then make 23 -> h_code=2. Break 23 -> h_code=1 (left still held). Break 1C -> h_code=0.
- PLAYER=1, state=4. Send E0,75 -> v_code=1. Send 75 (no E0) -> ignored. Send E0,F0,75 -> v_code=0. Send 1D -> ignored, v_code=0.
- BOOST_CYCLES=8, COOLDOWN_CYCLES=4, state=4. Make 12 -> boost high exactly 8 cycles, then 0. Key held past cooldown -> boost stays 0. Break then make 12 -> boost high again.
- Make 1D in state=3 -> v_code=0. state changes to 4 -> v_code=1 next cycle. Boost active, state=5 for 10 cycles -> boost=0 and counter frozen. Back to 4 -> boost resumes for the remaining count.
- Mid-sequence: send E0, assert rst one cycle, then send 75 (PLAYER=1) -> treated as non-extended, ignored. All outputs 0 after reset.
